// File: rtl/mem_access_ctrl_pkg.sv
// Shared types for the CPU memory-path sequencer.
// State codes, operation type and default timeout sizing.
package cpu_mem_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_RD_WAIT,
        S_RD_CAP,
        S_WR_LOAD,
        S_WR_WAIT,
        S_DONE,
        S_ERR
    } state_e;

    typedef enum logic {
        OP_RD,
        OP_WR
    } op_e;

    localparam int TIMEOUT_CYCLES_DEF = 16;
    localparam int CNT_W_DEF          = 5;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Control-unit / memory handshake bundle for mem_access_ctrl.
// master = control unit plus memory side, slave = the sequencer.
interface mem_access_ctrl_if;

    logic req_read;
    logic req_write;
    logic mem_ready;
    logic MARin;
    logic MDRin;
    logic MDRsel;
    logic mem_rd;
    logic mem_wr;
    logic busy;
    logic done;
    logic err;

    modport master (
        output req_read, req_write, mem_ready,
        input  MARin, MDRin, MDRsel, mem_rd, mem_wr,
        input  busy, done, err
    );

    modport slave (
        input  req_read, req_write, mem_ready,
        output MARin, MDRin, MDRsel, mem_rd, mem_wr,
        output busy, done, err
    );

endinterface

// File: rtl/mem_access_ctrl_timer.sv
// mem_wait_timer: counts WAIT cycles without mem_ready and flags expiry.
// Counter is held at zero whenever the sequencer is not waiting.
module mem_wait_timer #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic mem_ready,
    output logic expire
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = '0;
        if (run && !mem_ready) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Fires on the TIMEOUT_CYCLES-th stalled cycle; a ready on it wins.
    assign expire = run && !mem_ready &&
                    (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: one-at-a-time MAR/MDR read/write sequencer.
// Define MEM_TIMEOUT_EN to bound the WAIT states and enable err.
module mem_access_ctrl
    import cpu_mem_pkg::*;
`ifdef MEM_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int CNT_W          = CNT_W_DEF
)
`endif
(
    input logic               Clock,
    input logic               Clear,
    mem_access_ctrl_if.slave  bus
);

    state_e state_q;
    state_e state_d;
    op_e    op_q;
    op_e    op_d;
    logic   expire;

`ifdef MEM_TIMEOUT_EN
    logic in_wait;

    assign in_wait = (state_q == S_RD_WAIT) ||
                     (state_q == S_WR_WAIT);

    mem_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_timer (
        .clk       (Clock),
        .rst_n     (Clear),
        .run       (in_wait),
        .mem_ready (bus.mem_ready),
        .expire    (expire)
    );
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state_q <= S_IDLE;
            op_q    <= OP_RD;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        unique case (state_q)
            S_IDLE: begin
                // Read has priority when both requests arrive together.
                if (bus.req_read) begin
                    op_d    = OP_RD;
                    state_d = S_ADDR;
                end else if (bus.req_write) begin
                    op_d    = OP_WR;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                state_d = (op_q == OP_RD) ? S_RD_WAIT : S_WR_LOAD;
            end
            S_RD_WAIT: begin
                if (bus.mem_ready) state_d = S_RD_CAP;
                else if (expire)   state_d = S_ERR;
            end
            S_RD_CAP:  state_d = S_DONE;
            S_WR_LOAD: state_d = S_WR_WAIT;
            S_WR_WAIT: begin
                if (bus.mem_ready) state_d = S_DONE;
                else if (expire)   state_d = S_ERR;
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.MARin  = 1'b0;
        bus.MDRin  = 1'b0;
        bus.MDRsel = 1'b0;
        bus.mem_rd = 1'b0;
        bus.mem_wr = 1'b0;
        bus.done   = 1'b0;
        bus.err    = 1'b0;
        bus.busy   = (state_q != S_IDLE);
        unique case (state_q)
            S_ADDR:    bus.MARin  = 1'b1;
            S_RD_WAIT: bus.mem_rd = 1'b1;
            S_RD_CAP: begin
                bus.MDRin  = 1'b1;
                bus.MDRsel = 1'b1;
            end
            S_WR_LOAD: bus.MDRin  = 1'b1;
            S_WR_WAIT: bus.mem_wr = 1'b1;
            S_DONE:    bus.done   = 1'b1;
            S_ERR: begin
                bus.done = 1'b1;
`ifdef MEM_TIMEOUT_EN
                bus.err  = 1'b1;
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: per-cycle output vectors.
// Output byte = {err,done,busy,mem_wr,mem_rd,MDRsel,MDRin,MARin}.
module tb_mem_access_ctrl;

    logic Clock;
    logic Clear;
    logic req_read;
    logic req_write;
    logic mem_ready;
    logic [7:0] outs;

    int errs;
    int checks;

    logic [7:0] exp_v [0:63];
    logic [63:0] rdy_v;

    mem_access_ctrl_if bus ();

    assign bus.req_read  = req_read;
    assign bus.req_write = req_write;
    assign bus.mem_ready = mem_ready;

    assign outs = {bus.err, bus.done, bus.busy, bus.mem_wr,
                   bus.mem_rd, bus.MDRsel, bus.MDRin, bus.MARin};

    mem_access_ctrl dut (
        .Clock (Clock),
        .Clear (Clear),
        .bus   (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s: got %02h want %02h", tag, got, want);
        end
    endtask

    task automatic fill(input int lo, input int hi, input logic [7:0] v);
        for (int i = lo; i <= hi; i++) exp_v[i] = v;
    endtask

    // Called just after a posedge; cycle 0 is the cycle now starting.
    task automatic run_seq(input string tag, input logic rd,
                           input logic wr, input int n, input int hold);
        req_read  = rd;
        req_write = wr;
        mem_ready = rdy_v[0];
        for (int i = 0; i < n; i++) begin
            @(negedge Clock);
            chk($sformatf("%s_c%0d", tag, i), outs, exp_v[i]);
            chk($sformatf("%s_rdwr%0d", tag, i),
                {7'd0, bus.mem_rd & bus.mem_wr}, 8'h00);
            chk($sformatf("%s_marmdr%0d", tag, i),
                {7'd0, bus.MARin & bus.MDRin}, 8'h00);
            @(posedge Clock);
            #1;
            if (i + 1 >= hold) begin
                req_read  = 1'b0;
                req_write = 1'b0;
            end
            mem_ready = rdy_v[i+1];
        end
    endtask

    initial begin
        errs      = 0;
        checks    = 0;
        req_read  = 1'b0;
        req_write = 1'b0;
        mem_ready = 1'b0;
        Clear     = 1'b0;
        #3;
        chk("reset_outs", outs, 8'h00);
        #9;
        Clear = 1'b1;
        @(posedge Clock);
        #1;

        // Read, memory always ready
        rdy_v = '1;
        fill(0, 63, 8'h00);
        exp_v[1] = 8'h21;
        exp_v[2] = 8'h28;
        exp_v[3] = 8'h26;
        exp_v[4] = 8'h60;
        run_seq("rd", 1'b1, 1'b0, 6, 1);

        // Both requests: read wins
        run_seq("both", 1'b1, 1'b1, 6, 1);

        // Write, ready low cycles 0-5, high at 6
        rdy_v = 64'h0;
        rdy_v[63:6] = '1;
        fill(0, 63, 8'h00);
        exp_v[1] = 8'h21;
        exp_v[2] = 8'h22;
        fill(3, 6, 8'h30);
        exp_v[7] = 8'h60;
        run_seq("wr", 1'b0, 1'b1, 9, 1);

        // Back-to-back writes, req_write held through DONE
        rdy_v = '1;
        fill(0, 63, 8'h00);
        exp_v[1] = 8'h21;
        exp_v[2] = 8'h22;
        exp_v[3] = 8'h30;
        exp_v[4] = 8'h60;
        exp_v[6] = 8'h21;
        exp_v[7] = 8'h22;
        exp_v[8] = 8'h30;
        exp_v[9] = 8'h60;
        run_seq("b2b", 1'b0, 1'b1, 12, 6);

        // Stalled read: timeout or unbounded wait, ready from cycle 22
        rdy_v = 64'h0;
        rdy_v[63:22] = '1;
        fill(0, 63, 8'h00);
        exp_v[1] = 8'h21;
`ifdef MEM_TIMEOUT_EN
        fill(2, 17, 8'h28);
        exp_v[18] = 8'he0;
`else
        fill(2, 22, 8'h28);
        exp_v[23] = 8'h26;
        exp_v[24] = 8'h60;
`endif
        run_seq("stall", 1'b1, 1'b0, 27, 1);

        // Clear asserted while in RD_WAIT
        rdy_v = 64'h0;
        fill(0, 63, 8'h00);
        exp_v[1] = 8'h21;
        exp_v[2] = 8'h28;
        run_seq("prerst", 1'b1, 1'b0, 3, 1);
        #2;
        Clear = 1'b0;
        #1;
        chk("rst_async", outs, 8'h00);
        #2;
        Clear = 1'b1;
        @(posedge Clock);
        #1;
        rdy_v = '1;
        fill(0, 63, 8'h00);
        run_seq("postrst", 1'b0, 1'b0, 4, 1);

        // Normal read after the reset recovers
        exp_v[1] = 8'h21;
        exp_v[2] = 8'h28;
        exp_v[3] = 8'h26;
        exp_v[4] = 8'h60;
        run_seq("rd2", 1'b1, 1'b0, 6, 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
